noc_path_scheduler: RTL and testbench
=====================================

// Module: noc_path_scheduler
// PURPOSE
//  Arbitrates the four processors' path-configuration requests onto the 2x2 mesh.
//  Grants each source a path to one destination, holds it for a flit burst, then tears it down.
//  Sits between the processor request lines and the mesh pN_configure / block_all_paths inputs.
//  Guarantees at most one open path out of each node and at most one open path into each node.
// PARAMETERS
//  N_NODES       4    mesh nodes; the arbiter is written for 4
//  CFG_W         11   configure word width per node
//  LEN_W         7    burst-length field width (cfg[10:4])
//  SETUP_CYCLES  2    cycles the config is held before a burst counts as open
//  TIMEOUT       255  idle cycles in ACTIVE before forced teardown
// PORTS
//  clock            in   1      system clock, rising edge
//  reset            in   1      asynchronous, active-low; all state cleared while low
//  req_cfg          in   44     {p3,p2,p1,p0} request words; [3]=valid [2:1]=dest [0]=mode [10:4]=len
//  flit_done        in   4      1-cycle pulse per source: one flit of its burst delivered
//  hold_all         in   1      freeze new grants; open paths continue
//  p_configure      out  44     {p3..p0} words to mesh pN_configure, registered
//  block_all_paths  out  1      to mesh; high while hold_all high, or reset released <2 cycles ago
//  grant            out  4      1-cycle pulse: source granted this cycle
//  busy             out  4      source i is in SETUP, ACTIVE or TEARDOWN
//  err              out  4      1-cycle pulse: self-destination request or timeout on source i
// BEHAVIOUR
//  Reset values: all outputs 0, except block_all_paths=1. Channels IDLE, rr_ptr=0, dest_busy=0.
//  Arbiter: one grant per cycle. Scan sources from rr_ptr, wrapping mod 4.
//   - First eligible i wins: IDLE, req_cfg[i][3]=1, dest!=i, dest_busy[dest]=0, hold_all=0.
//   - On grant: rr_ptr<=i+1 mod 4, dest_busy[dest]<=1, grant[i]=1.
//   - The cfg word is latched; later req changes are ignored except the valid bit.
//  Self-destination (dest==i, valid=1, IDLE): err[i] pulses once per request and no grant is issued.
//   The error re-arms only after valid drops.
//  Channel FSM per source, one cycle per arrow:
//   IDLE -grant-> SETUP
//   SETUP: drive latched cfg on p_configure[i] for SETUP_CYCLES cycles -> ACTIVE.
//    Load cnt=len; len 0 counts as 128.
//   ACTIVE: p_configure[i] keeps latched cfg.
//    - flit_done[i]: cnt-1 and idle timer cleared. cnt reaching 0 -> TEARDOWN.
//    - Idle timer reaching TIMEOUT -> TEARDOWN with err[i] pulse.
//    - req valid dropping -> TEARDOWN next cycle.
//   TEARDOWN (1 cycle): p_configure[i]=0 and dest_busy[dest] cleared -> IDLE.
//    The destination is grantable again in the following cycle.
//  flit_done in IDLE or SETUP is ignored.
//  Simultaneous release and grant of the same dest in one cycle: the grant waits one cycle.
//  hold_all: no grants are issued; block_all_paths=1 in the same cycle (combinational OR with reset window).
//  Latency: request to grant = 1 cycle minimum; grant to p_configure valid = 1 cycle.
//  Reset asserted mid-burst: p_configure and busy drop immediately (async); no err pulse.
//  Counters saturate and never wrap; rr_ptr is 2 bits and wraps naturally.
// STRUCTURE
//  Shared package noc_pkg: CFG field offsets (VALID_B=3, DEST_LSB=1, MODE_B=0, LEN_LSB=4).
//   Also holds the FSM state encoding {IDLE,SETUP,ACTIVE,TEARDOWN} and N_NODES.
//  Sub-module noc_path_channel: per-source FSM with burst counter and timeout counter, instantiated 4x.
//  Top level: round-robin arbiter, dest_busy vector, output packing.
// TESTING
//  1. Reset low 17 cycles, release; p0 req cfg 11'h00B (dest 1, len 0 -> 128).
//     Expect grant[0] in cycle 1, p_configure[0]=11'h00B one cycle later.
//     Expect busy[0]=1 until 128 flit_done pulses, then p_configure[0]=0.
//  2. p0..p3 request 11'h01B, 11'h01D, 11'h01F, 11'h019 together (len 1, dests 1,2,3,0).
//     Expect grants in order p0,p1,p2,p3 on consecutive cycles, no dest conflict.
//  3. p0 and p2 both target dest 1. p0 is granted; p2 is held until the cycle after p0's TEARDOWN.
//     Repeat with rr_ptr=2: p2 wins.
//  4. p1 requests dest 1 (11'h00B): err[1] pulses once; no grant; busy[1] stays 0.
//  5. p3 granted with len 5 and no flit_done: TEARDOWN after 255 ACTIVE cycles with err[3] pulse.
//     Separately, dropping valid mid-burst -> TEARDOWN next cycle.
//  6. hold_all high while 2 paths are open: no new grants, block_all_paths=1, open bursts finish.
//     Reset pulled low mid-burst: all outputs 0 at once, block_all_paths=1.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared sizes, configure-word field offsets and channel state encoding
package noc_pkg;
  localparam int N_NODES      = 4;
  localparam int CFG_W        = 11;
  localparam int LEN_W        = 7;
  localparam int SETUP_CYCLES = 2;
  localparam int TIMEOUT      = 255;
  localparam int VALID_B      = 3;
  localparam int DEST_LSB     = 1;
  localparam int MODE_B       = 0;
  localparam int LEN_LSB      = 4;
  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, TEARDOWN} ch_state_e;
endpackage

// File: rtl/noc_path_channel.sv
// noc_path_channel: one source's path lifecycle with setup hold, burst count and idle timeout
module noc_path_channel
  import noc_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             grant,
  input  logic [CFG_W-1:0] req_cfg,
  input  logic             flit_done,
  output logic             busy,
  output logic             teardown,
  output logic [1:0]       dest,
  output logic [CFG_W-1:0] p_configure,
  output logic             err
);
  localparam logic [1:0] SETUP_LAST = 2'(SETUP_CYCLES - 1);
  localparam logic [7:0] TMR_LAST   = 8'(TIMEOUT - 1);
  ch_state_e        st, st_n;
  logic [CFG_W-1:0] cfg;
  logic [1:0]       sc, sc_n;
  logic [LEN_W:0]   cnt, cnt_n;
  logic [7:0]       tmr, tmr_n;
  logic             err_n;
  logic [LEN_W-1:0] len;
  assign len      = cfg[LEN_LSB +: LEN_W];
  assign busy     = st != IDLE;
  assign teardown = st == TEARDOWN;
  assign dest     = cfg[DEST_LSB +: 2];
  always_comb begin
    st_n  = st;
    sc_n  = sc;
    cnt_n = cnt;
    tmr_n = tmr;
    err_n = 1'b0;
    case (st)
      IDLE: begin
        st_n = grant ? SETUP : IDLE;
        sc_n = '0;
      end
      SETUP: begin
        sc_n = sc + 2'd1;
        if (sc == SETUP_LAST) begin
          st_n  = ACTIVE;
          cnt_n = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
          tmr_n = '0;
        end
      end
      ACTIVE:
        if (!req_cfg[VALID_B]) st_n = TEARDOWN;
        else if (flit_done) begin
          cnt_n = cnt - 8'd1;
          tmr_n = '0;
          if (cnt == 8'd1) st_n = TEARDOWN;
        end else if (tmr == TMR_LAST) begin
          st_n  = TEARDOWN;
          err_n = 1'b1;
        end else tmr_n = tmr + 8'd1;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st          <= IDLE;
      cfg         <= '0;
      sc          <= '0;
      cnt         <= '0;
      tmr         <= '0;
      err         <= 1'b0;
      p_configure <= '0;
    end else begin
      st          <= st_n;
      sc          <= sc_n;
      cnt         <= cnt_n;
      tmr         <= tmr_n;
      err         <= err_n;
      if (st == IDLE && grant) cfg <= req_cfg;
      p_configure <= (st == SETUP || st == ACTIVE) ? cfg : '0;
    end
endmodule

// File: rtl/noc_path_scheduler.sv
// noc_path_scheduler: round-robin grant of source-to-destination mesh paths with per-node exclusivity
module noc_path_scheduler
  import noc_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_NODES*CFG_W-1:0] req_cfg,
  input  logic [N_NODES-1:0]       flit_done,
  input  logic                     hold_all,
  output logic [N_NODES*CFG_W-1:0] p_configure,
  output logic                     block_all_paths,
  output logic [N_NODES-1:0]       grant,
  output logic [N_NODES-1:0]       busy,
  output logic [N_NODES-1:0]       err
);
  logic [1:0]         rr_ptr, rr_n, idx, rel_cnt;
  logic [N_NODES-1:0] dest_busy, dest_set, dest_clr, elig, valid, self_hit, armed;
  logic [N_NODES-1:0] gnt_n, teardown, ch_err, self_err;
  logic [1:0]         req_dest [N_NODES];
  logic [1:0]         ch_dest [N_NODES];
  for (genvar i = 0; i < N_NODES; i++) begin : g_ch
    assign valid[i]    = req_cfg[i*CFG_W + VALID_B];
    assign req_dest[i] = req_cfg[i*CFG_W + DEST_LSB +: 2];
    assign self_hit[i] = !busy[i] && valid[i] && req_dest[i] == 2'(i);
    assign elig[i]     = !busy[i] && valid[i] && req_dest[i] != 2'(i) && !dest_busy[req_dest[i]] && !hold_all;
    noc_path_channel u_ch (
      .clock       (clock),
      .reset       (reset),
      .grant       (gnt_n[i]),
      .req_cfg     (req_cfg[i*CFG_W +: CFG_W]),
      .flit_done   (flit_done[i]),
      .busy        (busy[i]),
      .teardown    (teardown[i]),
      .dest        (ch_dest[i]),
      .p_configure (p_configure[i*CFG_W +: CFG_W]),
      .err         (ch_err[i])
    );
  end
  always_comb begin
    gnt_n = '0;
    rr_n  = rr_ptr;
    idx   = rr_ptr;
    for (int k = 0; k < N_NODES; k++) begin
      if (gnt_n == '0 && elig[idx]) begin
        gnt_n[idx] = 1'b1;
        rr_n       = idx + 2'd1;
      end
      idx = idx + 2'd1;
    end
  end
  // a destination freed by TEARDOWN is only visible to the arbiter one cycle later
  always_comb begin
    dest_set = '0;
    dest_clr = '0;
    for (int j = 0; j < N_NODES; j++) begin
      if (gnt_n[j]) dest_set[req_dest[j]] = 1'b1;
      if (teardown[j]) dest_clr[ch_dest[j]] = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rr_ptr    <= '0;
      dest_busy <= '0;
      grant     <= '0;
      self_err  <= '0;
      armed     <= '1;
      rel_cnt   <= '0;
    end else begin
      rr_ptr    <= rr_n;
      dest_busy <= (dest_busy & ~dest_clr) | dest_set;
      grant     <= gnt_n;
      self_err  <= self_hit & armed;
      armed     <= ~valid | (armed & ~self_hit);
      rel_cnt   <= (rel_cnt == 2'd2) ? rel_cnt : rel_cnt + 2'd1;
    end
  assign err             = self_err | ch_err;
  assign block_all_paths = hold_all | (rel_cnt != 2'd2);
endmodule

// File: tb/tb_noc_path_scheduler.sv
// tb_noc_path_scheduler: directed checks of grant order, path lifetime, errors, hold and reset
module tb_noc_path_scheduler;
  logic        clock = 1'b0, reset = 1'b0, hold_all = 1'b0;
  logic [43:0] req_cfg = '0, p_configure;
  logic [3:0]  flit_done = '0, grant, busy, err;
  logic        block_all_paths;
  int          errors = 0, checks = 0;
  always #5 clock = ~clock;
  noc_path_scheduler dut (
    .clock(clock), .reset(reset), .req_cfg(req_cfg), .flit_done(flit_done), .hold_all(hold_all),
    .p_configure(p_configure), .block_all_paths(block_all_paths), .grant(grant), .busy(busy), .err(err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask
  task automatic setreq(input int i, input logic [10:0] v);
    req_cfg[i*11 +: 11] = v;
  endtask
  task automatic do_reset();
    reset = 1'b0; req_cfg = '0; flit_done = '0; hold_all = 1'b0;
    step(2);
    reset = 1'b1;
  endtask
  initial begin
    step(17);
    chk("rst_pcfg", p_configure, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_err", err, 0);
    chk("rst_block", block_all_paths, 1);
    // 1: single long burst, len 0 means 128 flits
    reset = 1'b1; setreq(0, 11'h00B);
    step(1);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 4'b0001);
    chk("t1_pcfg_early", p_configure, 0);
    chk("t1_block_win", block_all_paths, 1);
    step(1);
    chk("t1_pcfg", p_configure, 44'h00B);
    chk("t1_grant_pulse", grant, 0);
    chk("t1_block_off", block_all_paths, 0);
    flit_done = 4'b0001;
    step(1);
    step(127);
    chk("t1_busy_127", busy, 4'b0001);
    step(1);
    chk("t1_busy_td", busy, 4'b0001);
    chk("t1_pcfg_td", p_configure, 44'h00B);
    flit_done = '0; req_cfg = '0;
    step(1);
    chk("t1_busy_done", busy, 0);
    chk("t1_pcfg_done", p_configure, 0);
    chk("t1_err", err, 0);
    // 2: four simultaneous non-conflicting requests
    do_reset();
    setreq(0, 11'h01B); setreq(1, 11'h01D); setreq(2, 11'h01F); setreq(3, 11'h019);
    step(1); chk("t2_g0", grant, 4'b0001);
    step(1); chk("t2_g1", grant, 4'b0010);
    step(1); chk("t2_g2", grant, 4'b0100);
    step(1); chk("t2_g3", grant, 4'b1000);
    chk("t2_busy", busy, 4'b1111);
    chk("t2_pcfg", p_configure, {11'h000, 11'h01F, 11'h01D, 11'h01B});
    req_cfg = '0;
    step(5);
    chk("t2_busy_end", busy, 0);
    chk("t2_pcfg_end", p_configure, 0);
    // 3: destination conflict, rr_ptr=0 then rr_ptr=2
    setreq(0, 11'h01B); setreq(2, 11'h01B);
    step(1); chk("t3_g0", grant, 4'b0001);
    step(1); chk("t3_wait1", grant, 0);
    step(1); chk("t3_wait2", grant, 0);
    flit_done = 4'b0001;
    step(1); chk("t3_wait3", grant, 0);
    chk("t3_td", busy, 4'b0001);
    flit_done = '0; setreq(0, 11'h000);
    step(1); chk("t3_wait4", grant, 0);
    chk("t3_idle", busy, 0);
    step(1); chk("t3_g2", grant, 4'b0100);
    setreq(2, 11'h000);
    step(5);
    chk("t3_idle2", busy, 0);
    setreq(1, 11'h019);
    step(1); chk("t3_g1", grant, 4'b0010);
    setreq(1, 11'h000); setreq(0, 11'h01B); setreq(2, 11'h01B);
    step(1); chk("t3_rr2_win", grant, 4'b0100);
    req_cfg = '0;
    step(6);
    chk("t3_end", busy, 0);
    // 4: self-destination request
    setreq(1, 11'h00B);
    step(1);
    chk("t4_err", err, 4'b0010);
    chk("t4_nogrant", grant, 0);
    step(1); chk("t4_err_once", err, 0);
    step(1); chk("t4_busy", busy, 0);
    setreq(1, 11'h000);
    step(1);
    setreq(1, 11'h00B);
    step(1); chk("t4_rearm", err, 4'b0010);
    setreq(1, 11'h000);
    step(1);
    // 5: idle timeout, then valid drop mid-burst
    setreq(3, 11'h058);
    step(1); chk("t5_grant", grant, 4'b1000);
    step(256);
    chk("t5_err_early", err, 0);
    chk("t5_busy", busy, 4'b1000);
    chk("t5_pcfg", p_configure, {11'h058, 33'h0});
    step(1);
    chk("t5_err", err, 4'b1000);
    chk("t5_td", busy, 4'b1000);
    setreq(3, 11'h000);
    step(1);
    chk("t5_err_pulse", err, 0);
    chk("t5_idle", busy, 0);
    chk("t5_pcfg0", p_configure, 0);
    setreq(3, 11'h058);
    step(1); chk("t5b_grant", grant, 4'b1000);
    step(4);
    setreq(3, 11'h000);
    step(1);
    chk("t5b_td", busy, 4'b1000);
    chk("t5b_pcfg", p_configure, {11'h058, 33'h0});
    chk("t5b_noerr", err, 0);
    step(1);
    chk("t5b_idle", busy, 0);
    chk("t5b_pcfg0", p_configure, 0);
    // 6: hold_all with two open paths, then reset mid-burst
    do_reset();
    setreq(0, 11'h03B); setreq(1, 11'h03D);
    step(1); chk("t6_g0", grant, 4'b0001);
    step(1); chk("t6_g1", grant, 4'b0010);
    chk("t6_block_pre", block_all_paths, 0);
    hold_all = 1'b1; setreq(2, 11'h01F);
    #1 chk("t6_block_hold", block_all_paths, 1);
    step(2);
    chk("t6_hold_g", grant, 0);
    chk("t6_hold_busy", busy, 4'b0011);
    flit_done = 4'b0011;
    step(3);
    chk("t6_td", busy, 4'b0011);
    chk("t6_td_pcfg", p_configure, {22'h0, 11'h03D, 11'h03B});
    flit_done = '0;
    step(1);
    chk("t6_done", busy, 0);
    chk("t6_hold_g2", grant, 0);
    step(1);
    chk("t6_hold_g3", grant, 0);
    hold_all = 1'b0;
    #1 chk("t6_block_rel", block_all_paths, 0);
    step(1); chk("t6_g2", grant, 4'b0100);
    step(1); chk("t6_g0b", grant, 4'b0001);
    step(1); chk("t6_g1b", grant, 4'b0010);
    chk("t6_pcfg_open", p_configure, {11'h000, 11'h01F, 11'h000, 11'h03B});
    reset = 1'b0;
    #1;
    chk("t6_rst_pcfg", p_configure, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_block", block_all_paths, 1);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_grant", grant, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
